// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic {
    ARB_FREE = 1'b0,
    ARB_LOCK = 1'b1
  } ram_arb_state_e;

  // Index width for n requesters, at least one bit so a single requester still has a tag.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: first set request at or above ptr_i, wrapping modulo N.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [IdxW-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IdxW'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one single-port synchronous RAM with optional locked bursts.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ-1:0]               req_lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             ram_en_o,
  output logic                             ram_we_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic [DATA_WIDTH-1:0]            ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]            ram_rdata_i
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    return IdxW'((32'(i) + 1) % NUM_REQ);
  endfunction

  ram_arb_state_e  state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IdxW-1:0]       arb_idx, win_idx;
  logic                  arb_any, lock_hold, accept;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  logic                  ram_en_q, ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  rd1_q, rd2_q;
  logic [IdxW-1:0]       tag1_q, tag2_q;

  // While locked rr_ptr_q already equals owner+1, so a released lock searches from there.
  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign lock_hold = (state_q == ARB_LOCK) && req_valid_i[owner_q];

  always_comb begin
    req_ready_o = '0;
    win_idx     = arb_idx;
    accept      = 1'b0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    if (!rst_i) begin
      if (lock_hold) begin
        win_idx              = owner_q;
        accept               = 1'b1;
        req_ready_o[owner_q] = 1'b1;
        beat_cnt_d           = beat_cnt_q + 1'b1;
        if (!req_lock_i[owner_q] || (32'(beat_cnt_q) + 1 == MAX_BURST)) begin
          state_d  = ARB_FREE;
          rr_ptr_d = next_idx(owner_q);
        end
      end else begin
        state_d = ARB_FREE;
        if (arb_any) begin
          accept      = 1'b1;
          req_ready_o = arb_gnt;
          rr_ptr_d    = next_idx(arb_idx);
          if (req_lock_i[arb_idx] && (MAX_BURST > 1)) begin
            state_d    = ARB_LOCK;
            owner_d    = arb_idx;
            beat_cnt_d = CntW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    acc_addr  = req_addr_i[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    acc_wdata = req_wdata_i[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_FREE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd1_q       <= 1'b0;
      rd2_q       <= 1'b0;
      tag1_q      <= '0;
      tag2_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      ram_en_q   <= accept;
      ram_we_q   <= accept && req_we_i[win_idx];
      if (accept) begin
        ram_addr_q  <= acc_addr;
        ram_wdata_q <= acc_wdata;
      end
      rd1_q  <= accept && !req_we_i[win_idx];
      tag1_q <= win_idx;
      rd2_q  <= rd1_q;
      tag2_q <= tag1_q;
    end
  end

  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (rd2_q) begin
      rsp_valid_o[tag2_q] = 1'b1;
      rsp_rdata_o         = ram_rdata_i;
    end
  end

endmodule
